// File: rtl/selector_pantalla_n_if.sv
// Button inputs and selection outputs of the screen selector.
interface selector_pantalla_n_if #(
  parameter int unsigned N_STATES = 4
);
  localparam int unsigned IDX_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;

  logic             boton_izquierda;
  logic             boton_derecha;
  logic [IDX_W-1:0] indice;
  logic             cambio;
  logic             en_limite;

  // Button source / selection consumer side
  modport master (
    output boton_izquierda,
    output boton_derecha,
    input  indice,
    input  cambio,
    input  en_limite
  );

  // Selector side
  modport slave (
    input  boton_izquierda,
    input  boton_derecha,
    output indice,
    output cambio,
    output en_limite
  );
endinterface

// File: rtl/selector_pantalla_n.sv
// Two-button selection index over N_STATES values: per-button sync, debounce,
// press detection, optional auto-repeat, wrap/saturate stepping, change strobe.
module selector_pantalla_n #(
  parameter int unsigned N_STATES        = 4,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned REPEAT_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  selector_pantalla_n_if.slave bus
);

  localparam int unsigned IDX_W   = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_STATES - 1);

  typedef enum logic [1:0] {
    REP_IDLE = 2'd0,
    REP_HOLD = 2'd1,
    REP_RUN  = 2'd2
  } rep_state_t;

  // bit 0 = left (decrement), bit 1 = right (increment)
  logic [1:0] raw;
  logic [1:0] ev;

  assign raw = {bus.boton_derecha, bus.boton_izquierda};

  for (genvar b = 0; b < 2; b++) begin : g_boton
    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [DB_W-1:0]  db_cnt;
    logic             toggle;
    logic             press;
    logic             suelta;
    rep_state_t       st;
    rep_state_t       st_nx;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_inc;
    logic             fire;
    logic             ev_q;

    // Two-flop synchroniser on the raw button
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw[b];
        sync2 <= sync1;
      end
    end

    // Debounced state flips on the edge the disagreement run completes
    assign toggle = (sync2 != deb) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press  = toggle & sync2;
    assign suelta = toggle & ~sync2;

    // Debounce counter and debounced state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb    <= 1'b0;
        db_cnt <= '0;
      end else if (sync2 != deb) begin
        if (toggle) begin
          deb    <= ~deb;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= REP_IDLE;
      else        st <= st_nx;
    end

    // Repeat FSM next state: idle -> first-hold wait -> periodic repeat
    always_comb begin
      st_nx = st;
      case (st)
        REP_IDLE: if (press && (REPEAT_EN != 0)) st_nx = REP_HOLD;
        REP_HOLD: begin
          if (suelta)    st_nx = REP_IDLE;
          else if (fire) st_nx = REP_RUN;
        end
        REP_RUN:  if (suelta) st_nx = REP_IDLE;
        default:  st_nx = REP_IDLE;
      endcase
    end

    // Repeat FSM outputs: fire when the phase interval elapses
    always_comb begin
      fire    = 1'b0;
      rep_inc = rep_cnt + REP_W'(1);
      case (st)
        REP_HOLD: fire = ~suelta && (rep_inc == REP_W'(HOLD_CYCLES));
        REP_RUN:  fire = ~suelta && (rep_inc == REP_W'(REPEAT_CYCLES));
        default:  fire = 1'b0;
      endcase
    end

    // Repeat interval counter, restarted at press, each repeat and release
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  rep_cnt <= '0;
      else if ((st == REP_IDLE) || suelta || fire) rep_cnt <= '0;
      else                                         rep_cnt <= rep_inc;
    end

    // Registered step event: press or repeat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_q <= 1'b0;
      else        ev_q <= press | fire;
    end

    assign ev[b] = ev_q;
  end

  logic [IDX_W-1:0] indice;
  logic [IDX_W-1:0] indice_nx;
  logic             cambio;

  // Next index: single-direction events step, simultaneous events cancel
  always_comb begin
    indice_nx = indice;
    if (ev[1] && !ev[0]) begin
      if (indice == IDX_MAX) indice_nx = (WRAP != 0) ? '0 : indice;
      else                   indice_nx = indice + IDX_W'(1);
    end else if (ev[0] && !ev[1]) begin
      if (indice == '0) indice_nx = (WRAP != 0) ? IDX_MAX : indice;
      else              indice_nx = indice - IDX_W'(1);
    end
  end

  // Index register and change strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      indice <= '0;
      cambio <= 1'b0;
    end else begin
      indice <= indice_nx;
      cambio <= (indice_nx != indice);
    end
  end

  assign bus.indice    = indice;
  assign bus.cambio    = cambio;
  assign bus.en_limite = (indice == '0) || (indice == IDX_MAX);

endmodule

// File: tb/tb_selector_pantalla_n.sv
// Bench for selector_pantalla_n: three configurations driven by the same
// buttons, checked every cycle against a sample-history reference model.
module tb_selector_pantalla_n;

  localparam int N    = 5;
  localparam int DC   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst_n;
  logic der;
  logic izq;

  int n_tests = 0;
  int n_fail  = 0;
  int cam_cnt [3];

  always #5 clk = ~clk;

  selector_pantalla_n_if #(.N_STATES(N)) bus_a ();
  selector_pantalla_n_if #(.N_STATES(N)) bus_b ();
  selector_pantalla_n_if #(.N_STATES(N)) bus_c ();

  assign bus_a.boton_derecha   = der;
  assign bus_a.boton_izquierda = izq;
  assign bus_b.boton_derecha   = der;
  assign bus_b.boton_izquierda = izq;
  assign bus_c.boton_derecha   = der;
  assign bus_c.boton_izquierda = izq;

  selector_pantalla_n #(.N_STATES(N), .WRAP(1), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0),
                        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  selector_pantalla_n #(.N_STATES(N), .WRAP(0), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(0),
                        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  selector_pantalla_n #(.N_STATES(N), .WRAP(1), .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1),
                        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Reference model: per configuration wrap / repeat enables
  int wrap_p  [3] = '{1, 0, 1};
  int repen_p [3] = '{0, 0, 1};

  bit samp    [2][HMAX];
  int n_edge;
  bit deb_m   [2];
  bit held_m  [2];
  int age_m   [2];
  bit ev_m    [3][2];
  int exp_idx [3];
  bit exp_cam [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value the debounce logic sees at edge m: the raw sample two edges earlier
  function automatic int seen(input int b, input int m);
    if (m >= 2) return int'(samp[b][m-2]);
    return 0;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int b = 0; b < 2; b++) begin
      deb_m[b]  = 1'b0;
      held_m[b] = 1'b0;
      age_m[b]  = 0;
    end
    for (int d = 0; d < 3; d++) begin
      exp_idx[d] = 0;
      exp_cam[d] = 1'b0;
      ev_m[d][0] = 1'b0;
      ev_m[d][1] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int nv;
    bit all_diff, press, rel, rep;
    // apply last cycle's events to the index
    for (int d = 0; d < 3; d++) begin
      nv = exp_idx[d];
      if (ev_m[d][1] && !ev_m[d][0])
        nv = (wrap_p[d] != 0) ? (nv + 1) % N : ((nv + 1 > N - 1) ? N - 1 : nv + 1);
      else if (ev_m[d][0] && !ev_m[d][1])
        nv = (wrap_p[d] != 0) ? (nv + N - 1) % N : ((nv == 0) ? 0 : nv - 1);
      exp_cam[d] = (nv != exp_idx[d]);
      exp_idx[d] = nv;
    end
    // new events from the sample history
    for (int b = 0; b < 2; b++) begin
      samp[b][n_edge] = (b == 1) ? der : izq;
      all_diff = (n_edge >= DC - 1);
      for (int j = 0; j < DC; j++)
        if (all_diff && (seen(b, n_edge - j) == int'(deb_m[b]))) all_diff = 1'b0;
      press = all_diff && !deb_m[b];
      rel   = all_diff && deb_m[b];
      if (all_diff) deb_m[b] = ~deb_m[b];
      rep = 1'b0;
      if (press) begin
        held_m[b] = 1'b1;
        age_m[b]  = 0;
      end else if (rel) begin
        held_m[b] = 1'b0;
      end else if (held_m[b]) begin
        age_m[b]++;
        rep = (age_m[b] == HOLD) || (age_m[b] > HOLD && ((age_m[b] - HOLD) % REP) == 0);
      end
      for (int d = 0; d < 3; d++) ev_m[d][b] = press || ((repen_p[d] != 0) && rep);
    end
    if (n_edge < HMAX - 1) n_edge++;
  endtask

  task automatic check_all();
    chk("idx_a", 32'(bus_a.indice), exp_idx[0]);
    chk("idx_b", 32'(bus_b.indice), exp_idx[1]);
    chk("idx_c", 32'(bus_c.indice), exp_idx[2]);
    chk("cam_a", 32'(bus_a.cambio), 32'(exp_cam[0]));
    chk("cam_b", 32'(bus_b.cambio), 32'(exp_cam[1]));
    chk("cam_c", 32'(bus_c.cambio), 32'(exp_cam[2]));
    chk("lim_a", 32'(bus_a.en_limite), 32'(exp_idx[0] == 0 || exp_idx[0] == N - 1));
    chk("lim_b", 32'(bus_b.en_limite), 32'(exp_idx[1] == 0 || exp_idx[1] == N - 1));
    chk("lim_c", 32'(bus_c.en_limite), 32'(exp_idx[2] == 0 || exp_idx[2] == N - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all();
    if (bus_a.cambio === 1'b1) cam_cnt[0]++;
    if (bus_b.cambio === 1'b1) cam_cnt[1]++;
    if (bus_c.cambio === 1'b1) cam_cnt[2]++;
  endtask

  task automatic clear_cam();
    for (int d = 0; d < 3; d++) cam_cnt[d] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    clear_cam();
  endtask

  task automatic pulse(input bit right, input int hi, input int lo);
    if (right) der = 1'b1;
    else       izq = 1'b1;
    repeat (hi) tick();
    der = 1'b0;
    izq = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    int cb_before;
    int len;
    der   = 1'b0;
    izq   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    clear_cam();

    // reset state
    tick();
    tick();
    chk("rst_idx_a", 32'(bus_a.indice), 0);
    chk("rst_idx_b", 32'(bus_b.indice), 0);
    chk("rst_idx_c", 32'(bus_c.indice), 0);
    chk("rst_cam_a", 32'(bus_a.cambio), 0);
    chk("rst_lim_a", 32'(bus_a.en_limite), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // right held: single step without repeat, repeat schedule with it
    clear_cam();
    der = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 6)  chk("lat_pre_a", 32'(bus_a.indice), 0);
      if (i == 7)  chk("lat_idx_a", 32'(bus_a.indice), 1);
      if (i == 7)  chk("lat_cam_a", 32'(bus_a.cambio), 1);
      if (i == 8)  chk("lat_cam_off_a", 32'(bus_a.cambio), 0);
      if (i == 7)  chk("rep_press_c", 32'(bus_c.indice), 1);
      if (i == 14) chk("rep_wait_c", 32'(bus_c.indice), 1);
      if (i == 15) chk("rep1_c", 32'(bus_c.indice), 2);
      if (i == 18) chk("rep2_c", 32'(bus_c.indice), 3);
      if (i == 21) chk("rep3_c", 32'(bus_c.indice), 4);
      if (i == 24) chk("rep4_c", 32'(bus_c.indice), 0);
    end
    der = 1'b0;
    repeat (20) tick();
    chk("hold_cambios_a", 32'(cam_cnt[0]), 1);

    // five right presses then one left press
    do_reset();
    cb_before = 0;
    for (int p = 0; p < 5; p++) begin
      if (p == 4) cb_before = cam_cnt[1];
      pulse(1'b1, 6, 10);
      chk("press_a", 32'(bus_a.indice), (p + 1) % N);
      chk("press_b", 32'(bus_b.indice), (p + 1 > N - 1) ? N - 1 : p + 1);
      chk("press_c", 32'(bus_c.indice), (p + 1) % N);
    end
    chk("sat_hi_lim_b", 32'(bus_b.en_limite), 1);
    chk("sat_hi_cam_b", 32'(cam_cnt[1] - cb_before), 0);
    chk("five_cambios_a", 32'(cam_cnt[0]), 5);
    pulse(1'b0, 6, 10);
    chk("left_wrap_a", 32'(bus_a.indice), 4);
    chk("left_b", 32'(bus_b.indice), 3);
    chk("left_wrap_c", 32'(bus_c.indice), 4);

    // left press at zero
    do_reset();
    pulse(1'b0, 6, 10);
    chk("sat_lo_b", 32'(bus_b.indice), 0);
    chk("sat_lo_cam_b", 32'(cam_cnt[1]), 0);
    chk("wrap_lo_a", 32'(bus_a.indice), N - 1);

    // short pulse and chatter are rejected
    do_reset();
    pulse(1'b1, 3, 10);
    der = 1'b1; tick();
    der = 1'b0; tick();
    der = 1'b1; tick();
    der = 1'b0;
    repeat (10) tick();
    chk("glitch_idx_a", 32'(bus_a.indice), 0);
    chk("glitch_cam_a", 32'(cam_cnt[0]), 0);
    chk("glitch_cam_c", 32'(cam_cnt[2]), 0);

    // both buttons together cancel
    der = 1'b1;
    izq = 1'b1;
    repeat (12) tick();
    der = 1'b0;
    izq = 1'b0;
    repeat (12) tick();
    chk("both_idx_a", 32'(bus_a.indice), 0);
    chk("both_idx_c", 32'(bus_c.indice), 0);
    chk("both_cam_a", 32'(cam_cnt[0]), 0);

    // asynchronous reset mid-hold, held button re-presses after release
    der = 1'b1;
    repeat (10) tick();
    chk("pre_async_a", 32'(bus_a.indice), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_idx_a", 32'(bus_a.indice), 0);
    chk("async_idx_b", 32'(bus_b.indice), 0);
    chk("async_idx_c", 32'(bus_c.indice), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_cam();
    repeat (5) tick();
    chk("no_stale_a", 32'(bus_a.indice), 0);
    repeat (2) tick();
    chk("repress_a", 32'(bus_a.indice), 1);
    chk("repress_cam_a", 32'(cam_cnt[0]), 1);
    der = 1'b0;
    repeat (12) tick();

    // randomized button activity
    for (int s = 0; s < 80; s++) begin
      der = 1'($urandom_range(0, 1));
      izq = ($urandom_range(0, 3) == 0);
      len = int'($urandom_range(1, 14));
      repeat (len) tick();
    end
    der = 1'b0;
    izq = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_pantalla_n.md
Name: selector_pantalla_n

Overview:
- Parametrised successor to the two-button screen/mode selector counter.
- Takes raw left/right push-buttons and steps a selection index over N_STATES values.
- Adds per-button synchronisation and debounce, single-step-per-press edge detection, optional auto-repeat while held, wrap or saturate mode, and a one-cycle change strobe.
- Feeds display/mux logic that selects one of N screens or channels.

Parameters:
- N_STATES, 4: number of selectable values; index range 0..N_STATES-1; legal range 2..256.
- WRAP, 1: 1 = wrap at both ends; 0 = saturate at 0 and N_STATES-1.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised input must differ from its debounced state before that state changes; minimum 1.
- REPEAT_EN, 0: 1 = auto-repeat while a button stays held.
- HOLD_CYCLES, 8: cycles from the press event to the first repeat event.
- REPEAT_CYCLES, 3: cycles between subsequent repeat events.
- IDX_W: derived localparam = max(1, clog2(N_STATES)); not overridable.

Ports:
- clk, input, 1: single system clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- boton_izquierda, input, 1: raw left button, asynchronous, active-high; decrements the index.
- boton_derecha, input, 1: raw right button, asynchronous, active-high; increments the index.
- indice, output, IDX_W: current selection, registered.
- cambio, output, 1: one-cycle pulse coincident with any change of indice.
- en_limite, output, 1: high while indice == 0 or indice == N_STATES-1. Combinational from indice, no added latency.

Behaviour:
- Reset (rst_n low, asynchronous):
  - indice = 0, cambio = 0.
  - Synchronisers, debounced states, debounce counters and repeat counters all cleared.
  - Reset asserted mid-hold or mid-debounce discards all pending events.
  - After release, a button already held reads as a new press once debounced.
- Synchroniser: two flip-flops per button. No logic acts on the raw inputs.
- Debounce, per button:
  - Counter increments on each edge where the synchronised value differs from the debounced state.
  - Counter clears on any edge where they match.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Press event: debounced state 0->1. Release produces no event.
- Auto-repeat (REPEAT_EN = 1):
  - While the debounced state stays 1, the repeat counter runs from the press event.
  - First repeat event fires HOLD_CYCLES cycles after the press event.
  - Further repeat events fire every REPEAT_CYCLES cycles after that.
  - Release clears the counter immediately.
  - With REPEAT_EN = 0: exactly one event per press.
- Event resolution, per cycle: ev_der and ev_izq are each a press or repeat event.
  - Only ev_der: indice = indice+1. If indice == N_STATES-1: to 0 when WRAP=1, unchanged when WRAP=0.
  - Only ev_izq: indice = indice-1. If indice == 0: to N_STATES-1 when WRAP=1, unchanged when WRAP=0.
  - Both in the same cycle: no change, cambio = 0.
  - Neither: hold.
- cambio is 1 only in the cycle after an edge where indice actually changed. A saturated event gives cambio = 0.
- Latency:
  - Raw input stable high sampled at edge k gives a new indice visible after edge k+DEBOUNCE_CYCLES+2.
  - cambio is high for that same single cycle.
- Arithmetic: modulo N_STATES, not modulo 2^IDX_W. indice never holds a value >= N_STATES, including non-power-of-two N_STATES.

Test Plan (N_STATES=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3 unless stated):
- Reset, then right held 20 cycles then released, WRAP=1, REPEAT_EN=0:
  - indice goes 0 -> 1 exactly 6 edges after the first high sample.
  - One cambio pulse; no further change while held.
- Five separate right presses from 0, WRAP=1: indice 1,2,3,4,0; five cambio pulses. Then one left press: indice 4.
- WRAP=0:
  - From 4, right press: indice stays 4, cambio stays 0, en_limite = 1.
  - From 0, left press: indice stays 0.
- Right pulse 3 cycles wide, and a 1-0-1-0 chatter burst: no change to indice, cambio never asserted.
- REPEAT_EN=1, right held 20 cycles after debounce from 0:
  - Press event gives 1.
  - Repeats at +8, +11, +14, +17 cycles give 2, 3, 4, 0.
  - Release stops stepping.
- Both buttons raised on the same sample: no change. rst_n pulsed low mid-hold: indice = 0 immediately (asynchronous), no stale event after rst_n rises.
